// File: rtl/prog_loader.sv
// Boot-time program loader: takes a framed byte stream from the host link,
// assembles 16-bit instruction words, writes them into instruction memory
// while the core is held in reset, then releases the core on a good checksum.
module prog_loader #(
    parameter int          ADDR_W         = 12,
    parameter int          WORD_W         = 16,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int          TIMEOUT_CYCLES = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic              pause_toggle,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [WORD_W-1:0] imem_wdata,
    output logic              cpu_rst,
    output logic              run_en,
    output logic              busy,
    output logic              done,
    output logic              err
);

    // Index needs one extra bit so a full 2^ADDR_W-word image can be counted.
    localparam int          IDX_W     = ADDR_W + 1;
    localparam int          TW        = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] MAX_WORDS = 32'(1) << ADDR_W;

    typedef enum logic [2:0] {
        IDLE, CNT_HI, CNT_LO, DATA_HI, DATA_LO, CHK, RUN, ERR
    } state_t;

    state_t             state_reg, state_next;
    logic [15:0]        cnt_reg, cnt_next;
    logic [IDX_W-1:0]   idx_reg, idx_next;
    logic [7:0]         acc_reg, acc_next;
    logic [7:0]         hi_reg, hi_next;
    logic [TW-1:0]      idle_reg, idle_next;
    logic               we_reg, we_next;
    logic [ADDR_W-1:0]  addr_reg, addr_next;
    logic [WORD_W-1:0]  wdata_reg, wdata_next;
    logic               cpu_rst_reg, cpu_rst_next;
    logic               run_en_reg, run_en_next;
    logic               busy_reg, busy_next;
    logic               done_reg, done_next;
    logic               err_reg, err_next;

    logic               sync_hit;
    logic [15:0]        cnt_rx;
    logic [IDX_W-1:0]   idx_inc;

    assign sync_hit = rx_valid && (rx_data == SYNC_BYTE);
    assign cnt_rx   = {hi_reg, rx_data};
    assign idx_inc  = idx_reg + IDX_W'(1);

    // State and every output are registered here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            idx_reg     <= '0;
            acc_reg     <= '0;
            hi_reg      <= '0;
            idle_reg    <= '0;
            we_reg      <= 1'b0;
            addr_reg    <= '0;
            wdata_reg   <= '0;
            cpu_rst_reg <= 1'b1;
            run_en_reg  <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            err_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            idx_reg     <= idx_next;
            acc_reg     <= acc_next;
            hi_reg      <= hi_next;
            idle_reg    <= idle_next;
            we_reg      <= we_next;
            addr_reg    <= addr_next;
            wdata_reg   <= wdata_next;
            cpu_rst_reg <= cpu_rst_next;
            run_en_reg  <= run_en_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
            err_reg     <= err_next;
        end
    end

    // Frame parser: next state and next values of all registered outputs.
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        idx_next     = idx_reg;
        acc_next     = acc_reg;
        hi_next      = hi_reg;
        idle_next    = '0;
        we_next      = 1'b0;
        addr_next    = addr_reg;
        wdata_next   = wdata_reg;
        cpu_rst_next = cpu_rst_reg;
        run_en_next  = run_en_reg;
        done_next    = done_reg;
        err_next     = err_reg;

        case (state_reg)
            IDLE, ERR, RUN: begin
                // A new SYNC always restarts the load, even over a pause request.
                if (sync_hit) begin
                    state_next   = CNT_HI;
                    cpu_rst_next = 1'b1;
                    run_en_next  = 1'b0;
                    done_next    = 1'b0;
                    err_next     = 1'b0;
                    idx_next     = '0;
                    acc_next     = '0;
                end else if (state_reg == RUN && pause_toggle) begin
                    run_en_next = ~run_en_reg;
                end
            end
            default: begin
                if (rx_valid) begin
                    if (state_reg != CHK) begin
                        acc_next = acc_reg ^ rx_data;
                    end
                    case (state_reg)
                        CNT_HI: begin
                            hi_next    = rx_data;
                            state_next = CNT_LO;
                        end
                        CNT_LO: begin
                            cnt_next = cnt_rx;
                            if (cnt_rx == 16'd0 || 32'(cnt_rx) > MAX_WORDS) begin
                                state_next = ERR;
                                err_next   = 1'b1;
                            end else begin
                                state_next = DATA_HI;
                            end
                        end
                        DATA_HI: begin
                            hi_next    = rx_data;
                            state_next = DATA_LO;
                        end
                        DATA_LO: begin
                            we_next    = 1'b1;
                            addr_next  = idx_reg[ADDR_W-1:0];
                            wdata_next = {hi_reg, rx_data};
                            idx_next   = idx_inc;
                            state_next = (32'(idx_inc) == 32'(cnt_reg)) ? CHK : DATA_HI;
                        end
                        default: begin
                            // CHK byte: release the core only on an exact match.
                            if (rx_data == acc_reg) begin
                                state_next   = RUN;
                                cpu_rst_next = 1'b0;
                                run_en_next  = 1'b1;
                                done_next    = 1'b1;
                            end else begin
                                state_next = ERR;
                                err_next   = 1'b1;
                            end
                        end
                    endcase
                end else if (idle_reg == TO_LAST) begin
                    // Host went silent mid-frame: abandon the load.
                    state_next = ERR;
                    err_next   = 1'b1;
                end else begin
                    idle_next = idle_reg + TW'(1);
                end
            end
        endcase

        busy_next = (state_next == CNT_HI) || (state_next == CNT_LO) ||
                    (state_next == DATA_HI) || (state_next == DATA_LO) ||
                    (state_next == CHK);
    end

    assign imem_we    = we_reg;
    assign imem_addr  = addr_reg;
    assign imem_wdata = wdata_reg;
    assign cpu_rst    = cpu_rst_reg;
    assign run_en     = run_en_reg;
    assign busy       = busy_reg;
    assign done       = done_reg;
    assign err        = err_reg;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: a vector table for a good two-word load,
// plus hand-written sequences for checksum, count, timeout, pause and reset.
module tb_prog_loader;

    logic        clk;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        pause_toggle;
    logic        imem_we;
    logic [11:0] imem_addr;
    logic [15:0] imem_wdata;
    logic        cpu_rst;
    logic        run_en;
    logic        busy;
    logic        done;
    logic        err;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [27:0] wq[$];   // {addr, data} of every write seen

    prog_loader #(
        .ADDR_W(12), .WORD_W(16), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .pause_toggle(pause_toggle), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .cpu_rst(cpu_rst), .run_en(run_en),
        .busy(busy), .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Log writes away from the active edge.
    always @(negedge clk) begin
        if (imem_we) wq.push_back({imem_addr, imem_wdata});
    end

    typedef struct {
        logic [7:0]  b;
        logic        we;
        logic [11:0] addr;
        logic [15:0] wd;
        logic        cpu_rst;
        logic        run_en;
        logic        busy;
        logic        done;
        logic        err;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Present one byte for one cycle; returns 1 time unit after the sampling edge.
    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic pulse_pause();
        pause_toggle = 1'b1;
        @(posedge clk); #1;
        pause_toggle = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_status(input string tag, input logic c_rst, input logic r_en,
                                input logic bsy, input logic dn, input logic er);
        check({tag, ".cpu_rst"}, 32'(cpu_rst), 32'(c_rst));
        check({tag, ".run_en"},  32'(run_en),  32'(r_en));
        check({tag, ".busy"},    32'(busy),    32'(bsy));
        check({tag, ".done"},    32'(done),    32'(dn));
        check({tag, ".err"},     32'(err),     32'(er));
    endtask

    initial begin
        int n0;
        vecs[0] = '{8'hA5, 1'b0, 12'h000, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{8'h00, 1'b0, 12'h000, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{8'h02, 1'b0, 12'h000, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{8'h12, 1'b0, 12'h000, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{8'h34, 1'b1, 12'h000, 16'h1234, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{8'h56, 1'b0, 12'h000, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{8'h78, 1'b1, 12'h001, 16'h5678, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{8'h0A, 1'b0, 12'h000, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

        rst = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; pause_toggle = 1'b0;
        idle(3);
        check("reset.we", 32'(imem_we), 32'd0);
        check("reset.addr", 32'(imem_addr), 32'd0);
        check("reset.wdata", 32'(imem_wdata), 32'd0);
        check_status("reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        idle(2);

        // Good two-word load, table-driven.
        for (int i = 0; i < 8; i++) begin
            send(vecs[i].b);
            $display("vec %0d rx=%h we=%b addr=%h wdata=%h cpu_rst=%b run_en=%b busy=%b done=%b err=%b",
                     i, vecs[i].b, imem_we, imem_addr, imem_wdata, cpu_rst, run_en, busy, done, err);
            check($sformatf("vec%0d.we", i), 32'(imem_we), 32'(vecs[i].we));
            if (vecs[i].we) begin
                check($sformatf("vec%0d.addr", i), 32'(imem_addr), 32'(vecs[i].addr));
                check($sformatf("vec%0d.wdata", i), 32'(imem_wdata), 32'(vecs[i].wd));
            end
            check_status($sformatf("vec%0d", i), vecs[i].cpu_rst, vecs[i].run_en,
                         vecs[i].busy, vecs[i].done, vecs[i].err);
        end
        idle(1);
        check("good.nwrites", 32'(wq.size()), 32'd2);
        if (wq.size() == 2) begin
            check("good.w0", 32'(wq[0]), {4'h0, 12'h000, 16'h1234});
            check("good.w1", 32'(wq[1]), {4'h0, 12'h001, 16'h5678});
        end

        // In RUN: pause twice, then pause outside RUN must be ignored later.
        pulse_pause();
        $display("pause1 run_en=%b", run_en);
        check("pause1.run_en", 32'(run_en), 32'd0);
        pulse_pause();
        $display("pause2 run_en=%b", run_en);
        check("pause2.run_en", 32'(run_en), 32'd1);

        // Bad checksum.
        n0 = wq.size();
        send(8'hA5); send(8'h00); send(8'h02); send(8'h12);
        send(8'h34); send(8'h56); send(8'h78); send(8'h0B);
        $display("badchk cpu_rst=%b run_en=%b busy=%b done=%b err=%b", cpu_rst, run_en, busy, done, err);
        check_status("badchk", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(1);
        check("badchk.nwrites", 32'(wq.size() - n0), 32'd2);
        pulse_pause();
        check("errpause.run_en", 32'(run_en), 32'd0);

        // CNT == 0.
        n0 = wq.size();
        send(8'hA5); send(8'h00);
        check("cnt0.busy_mid", 32'(busy), 32'd1);
        check("cnt0.err_mid", 32'(err), 32'd0);
        send(8'h00);
        $display("cnt0 busy=%b err=%b", busy, err);
        check_status("cnt0", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(2);
        check("cnt0.nwrites", 32'(wq.size() - n0), 32'd0);

        // CNT one beyond the memory size.
        send(8'hA5); send(8'h10); send(8'h01);
        $display("cntbig busy=%b err=%b", busy, err);
        check_status("cntbig", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

        // Timeout in the middle of a word.
        n0 = wq.size();
        send(8'hA5); send(8'h00); send(8'h01); send(8'h12);
        idle(10);
        check("tmo.busy_early", 32'(busy), 32'd1);
        check("tmo.err_early", 32'(err), 32'd0);
        idle(10);
        $display("timeout busy=%b err=%b", busy, err);
        check_status("tmo", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        check("tmo.nwrites", 32'(wq.size() - n0), 32'd0);

        // Reload the good image, then SYNC together with pause in RUN.
        for (int i = 0; i < 8; i++) send(vecs[i].b);
        check_status("reload", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        pause_toggle = 1'b1;
        send(8'hA5);
        pause_toggle = 1'b0;
        $display("sync+pause cpu_rst=%b run_en=%b busy=%b", cpu_rst, run_en, busy);
        check_status("syncpause", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        send(8'h00);

        // Asynchronous reset mid-frame, checked before any clock edge.
        #2;
        rst = 1'b1;
        #1;
        $display("async rst busy=%b cpu_rst=%b", busy, cpu_rst);
        check("arst.we", 32'(imem_we), 32'd0);
        check("arst.addr", 32'(imem_addr), 32'd0);
        check("arst.wdata", 32'(imem_wdata), 32'd0);
        check_status("arst", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(2);
        rst = 1'b0;
        idle(2);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/prog_loader.md
# prog_loader

Boot-time program loader sitting directly upstream of the single-cycle CPU core. It receives a framed byte stream from the host-link receiver, assembles 16-bit instruction words, and writes them into instruction memory while holding the core in reset. After a valid checksum it releases the core and drives its `run_en` pause control.

## Interface
- `ADDR_W`, 12: instruction memory address width.
- `WORD_W`, 16: instruction word width; fixed at 2 bytes.
- `SYNC_BYTE`, 8'hA5: frame start marker.
- `TIMEOUT_CYCLES`, 1000000: maximum idle cycles allowed between bytes inside a frame.
- `clk`  in  1  single clock.
- `rst`  in  1  asynchronous, active-high reset.
- `rx_data`  in  8  received byte.
- `rx_valid`  in  1  one-cycle strobe per byte; may be asserted back-to-back.
- `pause_toggle`  in  1  one-cycle pulse that toggles `run_en` while in RUN.
- `imem_we`  out  1  instruction memory write strobe.
- `imem_addr`  out  ADDR_W  write address.
- `imem_wdata`  out  WORD_W  write data.
- `cpu_rst`  out  1  reset to the core and register file.
- `run_en`  out  1  core run enable.
- `busy`  out  1  frame reception in progress.
- `done`  out  1  last frame loaded successfully.
- `err`  out  1  last frame failed.

## Operation
- Frame format: SYNC, CNT_HI, CNT_LO, then CNT words sent high byte first, then CHK.
  - CNT is the 16-bit word count.
  - CHK is the XOR of all bytes after SYNC, excluding CHK itself.
- FSM states: IDLE, CNT_HI, CNT_LO, DATA_HI, DATA_LO, CHK, RUN, ERR. All outputs are registered.
- IDLE/ERR/RUN, byte == SYNC_BYTE → CNT_HI.
  - On entry: `cpu_rst`=1, `run_en`=0, `done`=0, `err`=0, word index=0, checksum accumulator=0.
  - Non-SYNC bytes in these states are ignored.
- CNT_HI → CNT_LO → DATA_HI.
  - CNT==0 or CNT > 2^ADDR_W → ERR when the CNT_LO byte is sampled.
- DATA_HI stores the high byte → DATA_LO.
- DATA_LO sampled: `imem_wdata`={hi,lo}, `imem_addr`=word index, and `imem_we`=1 for one cycle.
  - Word index then increments.
  - If index+1 == CNT → CHK, otherwise → DATA_HI.
- CHK: byte == accumulator → RUN with `cpu_rst`=0, `run_en`=1, `done`=1. Otherwise → ERR with `err`=1.
- RUN: `pause_toggle` inverts `run_en`.
- ERR: `cpu_rst`=1 and `run_en`=0 are held until the next SYNC.
- Timeout: an idle counter runs in CNT_HI through CHK.
  - It resets on every accepted `rx_valid`.
  - Reaching TIMEOUT_CYCLES-1 → ERR with `err`=1.
- `busy`=1 exactly in states CNT_HI through CHK.
- Simultaneous `rx_valid`=SYNC and `pause_toggle` in RUN: the reload wins and `run_en` is forced to 0.
- `pause_toggle` outside RUN is ignored.
- An `rst` mid-frame aborts the load. Memory contents already written are left as is.

## Timing
- Reset values: state IDLE, `cpu_rst`=1, `run_en`=0, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `busy`=0, `done`=0, `err`=0, all counters 0.
- A byte sampled at edge N changes the state and registered outputs at edge N; they are visible during cycle N→N+1.
- `imem_we` is high for exactly the one cycle following the edge that sampled a DATA_LO byte.
  - Back-to-back bytes give at most one write every 2 cycles.
- CHK is sampled at the earliest one edge after the last write edge. The final write therefore completes before `cpu_rst` falls.
- `cpu_rst` falls and `run_en` rises on the same edge that samples a correct CHK.
- `pause_toggle` takes effect on the edge at which it is sampled.

## Test plan
- Load two words: A5,00,02,12,34,56,78,0A.
  - Required: writes addr0=16'h1234, then addr1=16'h5678.
  - Then `cpu_rst`=0, `run_en`=1, `done`=1, `err`=0.
- Same frame with CHK=0B → no release; `err`=1, `cpu_rst`=1, `done`=0.
- CNT=0 (A5,00,00) → ERR after the third byte, with zero writes.
- CNT=16'h1001 → ERR after the CNT_LO byte.
- Timeout: with TIMEOUT_CYCLES=16, send A5,00,01,12, then idle 20 cycles → `err`=1, `busy`=0, one write never issued.
- In RUN, pulse `pause_toggle` twice → `run_en` 1→0→1.
  - Then send SYNC together with `pause_toggle` → `cpu_rst`=1, `run_en`=0, `busy`=1.
  - Assert `rst` mid-frame → all outputs return to their reset values asynchronously.
